// File: rtl/tdc_bank_axi_regs.sv
// AXI4-Lite register file for the TDC bank IP (S00_AXI responder side).
//
// Four 32-bit read/write registers at byte offsets 0x0/0x4/0x8/0xC, with
// register contents and one-cycle write pulses exported to the TDC core.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN   clock, asynchronous active-low reset
//   S_AXI_AW*/W*/B*             write address, write data, write response
//   S_AXI_AR*/R*                read address, read data
//   reg0_o..reg3_o              current register contents
//   wr_pulse_o                  bit k high for one cycle after register k is written
module tdc_bank_axi_regs #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
  output logic [3:0]                      wr_pulse_o
);

  localparam int unsigned Dw = C_S_AXI_DATA_WIDTH;
  localparam int unsigned Sw = C_S_AXI_DATA_WIDTH / 8;

  // Write path state
  logic          aw_full_q, aw_full_d;
  logic [1:0]    awaddr_q, awaddr_d;
  logic          w_full_q, w_full_d;
  logic [Dw-1:0] wdata_q, wdata_d;
  logic [Sw-1:0] wstrb_q, wstrb_d;
  logic          bvalid_q, bvalid_d;
  logic [3:0]    wr_pulse_q, wr_pulse_d;

  // Read path state
  logic          rvalid_q, rvalid_d;
  logic [Dw-1:0] rdata_q, rdata_d;

  logic [Dw-1:0] regs_q [4];
  logic [Dw-1:0] regs_d [4];

  logic          aw_hs, w_hs, ar_hs, commit;
  logic [1:0]    addr_eff;
  logic [Dw-1:0] data_eff;
  logic [Sw-1:0] strb_eff;

  // Readies are gated by reset so they read 0 while reset is held.
  assign S_AXI_AWREADY = S_AXI_ARESETN & ~aw_full_q & ~bvalid_q;
  assign S_AXI_WREADY  = S_AXI_ARESETN & ~w_full_q & ~bvalid_q;
  assign S_AXI_ARREADY = S_AXI_ARESETN & ~rvalid_q;

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  // Commit on the edge where both halves are held or arriving, so the register,
  // pulse and BVALID all appear in the cycle after the last handshake.
  assign commit   = (aw_full_q | aw_hs) & (w_full_q | w_hs);
  assign addr_eff = aw_full_q ? awaddr_q : S_AXI_AWADDR[3:2];
  assign data_eff = w_full_q ? wdata_q : S_AXI_WDATA;
  assign strb_eff = w_full_q ? wstrb_q : S_AXI_WSTRB;

  always_comb begin
    aw_full_d  = aw_full_q;
    awaddr_d   = awaddr_q;
    w_full_d   = w_full_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    wr_pulse_d = '0;
    for (int k = 0; k < 4; k++) begin
      regs_d[k] = regs_q[k];
    end

    if (aw_hs) begin
      aw_full_d = 1'b1;
      awaddr_d  = S_AXI_AWADDR[3:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      wdata_d  = S_AXI_WDATA;
      wstrb_d  = S_AXI_WSTRB;
    end

    if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    if (commit) begin
      for (int b = 0; b < Sw; b++) begin
        if (strb_eff[b]) begin
          regs_d[addr_eff][b*8 +: 8] = data_eff[b*8 +: 8];
        end
      end
      wr_pulse_d[addr_eff] = 1'b1;
      aw_full_d            = 1'b0;
      w_full_d             = 1'b0;
      bvalid_d             = 1'b1;
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      // Reads the flopped value, so a same-edge commit returns the old data.
      rdata_d  = regs_q[S_AXI_ARADDR[3:2]];
      rvalid_d = 1'b1;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_full_q  <= 1'b0;
      awaddr_q   <= '0;
      w_full_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      wr_pulse_q <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      for (int k = 0; k < 4; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      aw_full_q  <= aw_full_d;
      awaddr_q   <= awaddr_d;
      w_full_q   <= w_full_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      wr_pulse_q <= wr_pulse_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      for (int k = 0; k < 4; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  assign S_AXI_BRESP  = 2'b00;
  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_RRESP  = 2'b00;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RDATA  = rdata_q;
  assign wr_pulse_o   = wr_pulse_q;
  assign reg0_o       = regs_q[0];
  assign reg1_o       = regs_q[1];
  assign reg2_o       = regs_q[2];
  assign reg3_o       = regs_q[3];

  // Protection bits and byte-offset address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_tdc_bank_axi_regs.sv
// Directed self-checking bench for tdc_bank_axi_regs.
module tb_tdc_bank_axi_regs;

  logic        clk;
  logic        rst_n;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] reg0, reg1, reg2, reg3;
  logic [3:0]  wr_pulse;

  int n_checks = 0;
  int n_errors = 0;

  tdc_bank_axi_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR (awaddr),
    .S_AXI_AWPROT (awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA  (wdata),
    .S_AXI_WSTRB  (wstrb),
    .S_AXI_WVALID (wvalid),
    .S_AXI_WREADY (wready),
    .S_AXI_BRESP  (bresp),
    .S_AXI_BVALID (bvalid),
    .S_AXI_BREADY (bready),
    .S_AXI_ARADDR (araddr),
    .S_AXI_ARPROT (arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA  (rdata),
    .S_AXI_RRESP  (rresp),
    .S_AXI_RVALID (rvalid),
    .S_AXI_RREADY (rready),
    .reg0_o       (reg0),
    .reg1_o       (reg1),
    .reg2_o       (reg2),
    .reg3_o       (reg3),
    .wr_pulse_o   (wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents AW and W together; returns 1 ns after the edge of the last handshake.
  task automatic write_cmd(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    logic aw_done, w_done, aw_now, w_now;
    aw_done = 1'b0;
    w_done  = 1'b0;
    awaddr  = a;
    wdata   = d;
    wstrb   = s;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    for (int i = 0; i < 16 && !(aw_done && w_done); i++) begin
      @(negedge clk);
      aw_now = awvalid & awready;
      w_now  = wvalid & wready;
      @(posedge clk);
      #1;
      if (aw_now) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_now)  begin wvalid  = 1'b0; w_done  = 1'b1; end
    end
    if (!(aw_done && w_done)) begin
      check("write_handshake_timeout", 32'(aw_done & w_done), 32'd1);
      awvalid = 1'b0;
      wvalid  = 1'b0;
    end
  endtask

  // Full write with BREADY high: expects response, pulse and register in the next cycle.
  task automatic write_full(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    write_cmd(a, d, s);
    @(negedge clk);
    check("b_valid", 32'(bvalid), 32'd1);
    check("b_resp", 32'(bresp), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
    logic done, now;
    done    = 1'b0;
    araddr  = a;
    arvalid = 1'b1;
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge clk);
      now = arvalid & arready;
      @(posedge clk);
      #1;
      if (now) begin arvalid = 1'b0; done = 1'b1; end
    end
    arvalid = 1'b0;
    check({tag, "_ar_done"}, 32'(done), 32'd1);
    @(negedge clk);
    check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    check({tag, "_rdata"}, rdata, exp);
    check({tag, "_rresp"}, 32'(rresp), 32'd0);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] vals [4];

  initial begin
    rst_n   = 1'b0;
    awaddr  = '0; awprot = '0; awvalid = 1'b0;
    wdata   = '0; wstrb  = '0; wvalid  = 1'b0;
    bready  = 1'b1;
    araddr  = '0; arprot = '0; arvalid = 1'b0;
    rready  = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_regs", reg0 | reg1 | reg2 | reg3, 32'd0);
    check("rst_valids", {28'd0, bvalid, rvalid, 2'b00}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_readys", {29'd0, awready, wready, arready}, 32'd7);
    @(posedge clk);
    #1;

    // Basic writes with pulse checks, then readback
    for (int k = 0; k < 4; k++) begin
      write_cmd(4'(k * 4), 32'(k + 1), 4'hF);
      @(negedge clk);
      check("t1_pulse", 32'(wr_pulse), 32'(4'b0001 << k));
      check("t1_bvalid", 32'(bvalid), 32'd1);
      check("t1_bresp", 32'(bresp), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("t1_pulse_clr", 32'(wr_pulse), 32'd0);
      check("t1_bvalid_clr", 32'(bvalid), 32'd0);
      @(posedge clk);
      #1;
    end
    vals[0] = reg0; vals[1] = reg1; vals[2] = reg2; vals[3] = reg3;
    for (int k = 0; k < 4; k++) check("t1_regk", vals[k], 32'(k + 1));
    axi_read(4'h0, 32'h1, "t1_rd0");
    axi_read(4'h4, 32'h2, "t1_rd1");
    axi_read(4'h8, 32'h3, "t1_rd2");
    axi_read(4'hC, 32'h4, "t1_rd3");

    // Byte strobes
    write_full(4'h8, 32'hFFFF_FFFF, 4'hF);
    write_full(4'h8, 32'h00AB_0000, 4'b0100);
    check("t2_reg2", reg2, 32'hFFAB_FFFF);

    // W three cycles before AW
    wdata  = 32'hDEAD_BEEF;
    wstrb  = 4'hF;
    wvalid = 1'b1;
    @(negedge clk);
    check("t3_wready_pre", 32'(wready), 32'd1);
    @(posedge clk);
    #1;
    wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t3_wready_low", 32'(wready), 32'd0);
      check("t3_bvalid_low", 32'(bvalid), 32'd0);
      @(posedge clk);
      #1;
    end
    awaddr  = 4'h4;
    awvalid = 1'b1;
    @(negedge clk);
    check("t3_awready", 32'(awready), 32'd1);
    check("t3_bvalid_before", 32'(bvalid), 32'd0);
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    @(negedge clk);
    check("t3_bvalid", 32'(bvalid), 32'd1);
    check("t3_reg1", reg1, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;

    // B backpressure; a second write is held off until the B handshake
    bready = 1'b0;
    write_cmd(4'h4, 32'h1234_5678, 4'hF);
    awaddr  = 4'h4;
    wdata   = 32'h0000_CAFE;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_bvalid_hold", 32'(bvalid), 32'd1);
      check("t4_readys_low", {30'd0, awready, wready}, 32'd0);
      check("t4_reg1_hold", reg1, 32'h1234_5678);
      @(posedge clk);
      #1;
    end
    bready = 1'b1;
    @(negedge clk);
    check("t4_bvalid_last", 32'(bvalid), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t4_second_accept", {30'd0, awready, wready}, 32'd3);
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    @(negedge clk);
    check("t4_second_b", 32'(bvalid), 32'd1);
    check("t4_reg1_new", reg1, 32'h0000_CAFE);
    @(posedge clk);
    #1;

    // Read and commit on the same edge to reg0
    awaddr  = 4'h0;
    wdata   = 32'h55;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    araddr  = 4'h0;
    arvalid = 1'b1;
    @(negedge clk);
    check("t5_all_ready", {29'd0, awready, wready, arready}, 32'd7);
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    arvalid = 1'b0;
    @(negedge clk);
    check("t5_rvalid", 32'(rvalid), 32'd1);
    check("t5_rdata_old", rdata, 32'h1);
    check("t5_reg0", reg0, 32'h55);
    @(posedge clk);
    #1;
    axi_read(4'h0, 32'h55, "t5_rd_new");

    // Reset while BVALID is pending
    bready = 1'b0;
    write_cmd(4'hC, 32'h0000_0077, 4'hF);
    @(negedge clk);
    check("t6_bvalid", 32'(bvalid), 32'd1);
    check("t6_reg3", reg3, 32'h77);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_bvalid", 32'(bvalid), 32'd0);
    check("t6_rst_regs", reg0 | reg1 | reg2 | reg3, 32'd0);
    check("t6_rst_readys", {29'd0, awready, wready, arready}, 32'd0);
    check("t6_rst_misc", {27'd0, wr_pulse, rvalid}, 32'd0);
    check("t6_rst_rdata", rdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    bready = 1'b1;
    @(posedge clk);
    #1;
    axi_read(4'hC, 32'h0, "t6_rd3");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
